// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// state encodings, default datapath width and the iteration counter sizing.
package md_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

  // Iteration counter must hold 0..width-1 with headroom for the compare.
  function automatic int cntWidth(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/md_abs_neg.sv
// Conditional two's-complement negate. Used with Negate = signed & msb to
// form an absolute value, and with Negate = result-sign to restore a sign.
module md_abs_neg
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] Value,
  input  logic             Negate,
  output logic [WIDTH-1:0] Result
);

  // Pure combinational negate; -Value of the most negative number wraps to itself.
  assign Result = Negate ? -Value : Value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per clock: shift-add for multiply, restoring
// shift-subtract for divide, followed by a single sign-fix cycle.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] MoveData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CntW = cntWidth(WIDTH);

  md_state_e          state;
  md_state_e          nextState;
  logic [CntW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic               isDiv;
  logic               negQ;
  logic               negR;
  logic               bZero;

  logic               accept;
  logic               moveOk;
  logic               lastStep;
  logic               opSigned;
  logic               opIsDiv;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     sumMul;
  logic [WIDTH:0]     trialDiv;
  logic [2*WIDTH-1:0] accNext;
  logic [2*WIDTH-1:0] prodFixed;
  logic [WIDTH-1:0]   quoFixed;
  logic [WIDTH-1:0]   remFixed;
  logic [WIDTH-1:0]   hiRes;
  logic [WIDTH-1:0]   loRes;

  assign accept   = (state == S_IDLE) && Start;
  assign moveOk   = (state == S_IDLE) && !Start;
  assign lastStep = (cnt == CntW'(WIDTH - 1));
  assign opSigned = (Op == MD_MULT) || (Op == MD_DIV);
  assign opIsDiv  = (Op == MD_DIV) || (Op == MD_DIVU);
  assign Busy     = (state != S_IDLE);

  // Operand conditioning: magnitudes for signed ops, raw values otherwise.
  md_abs_neg #(.WIDTH(WIDTH)) uAbsA (
    .Value (A),
    .Negate(opSigned & A[WIDTH-1]),
    .Result(absA)
  );

  md_abs_neg #(.WIDTH(WIDTH)) uAbsB (
    .Value (B),
    .Negate(opSigned & B[WIDTH-1]),
    .Result(absB)
  );

  // Result sign correction for product, quotient and remainder.
  md_abs_neg #(.WIDTH(2 * WIDTH)) uFixProd (
    .Value (acc),
    .Negate(negQ),
    .Result(prodFixed)
  );

  md_abs_neg #(.WIDTH(WIDTH)) uFixQuo (
    .Value (acc[WIDTH-1:0]),
    .Negate(negQ),
    .Result(quoFixed)
  );

  md_abs_neg #(.WIDTH(WIDTH)) uFixRem (
    .Value (acc[2*WIDTH-1:WIDTH]),
    .Negate(negR),
    .Result(remFixed)
  );

  // Partial sum for multiply and trial subtraction of the shifted remainder for divide.
  assign sumMul   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
  assign trialDiv = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};

  // One radix-2 iteration of the accumulator.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    accNext = acc;
    if (isDiv) begin
      if (trialDiv[WIDTH]) begin
        accNext = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
        accNext = {trialDiv[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else if (acc[0]) begin
      accNext = {sumMul, acc[WIDTH-1:1]};
    end else begin
      accNext = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // Final HI/LO values; a zero divisor forces an all-ones quotient.
  always_comb begin
    hiRes = prodFixed[2*WIDTH-1:WIDTH];
    loRes = prodFixed[WIDTH-1:0];
    if (isDiv) begin
      hiRes = remFixed;
      loRes = bZero ? '1 : quoFixed;
    end
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next-state: IDLE -> CALC for WIDTH steps -> FIX -> IDLE.
  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:  if (Start) nextState = S_CALC;
      S_CALC:  if (lastStep) nextState = S_FIX;
      S_FIX:   nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  // Datapath: latch conditioned operands on accept, iterate while in CALC.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc     <= '0;
      operand <= '0;
      cnt     <= '0;
      isDiv   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      bZero   <= 1'b0;
    end else if (accept) begin
      acc     <= {{WIDTH{1'b0}}, (opIsDiv ? absA : absB)};
      operand <= opIsDiv ? absB : absA;
      cnt     <= '0;
      isDiv   <= opIsDiv;
      negQ    <= opSigned & (A[WIDTH-1] ^ B[WIDTH-1]);
      negR    <= opSigned & A[WIDTH-1];
      bZero   <= (B == '0);
    end else if (state == S_CALC) begin
      acc <= accNext;
      cnt <= cnt + CntW'(1);
    end
  end

  // Architectural HI/LO, Done pulse and divide-by-zero flag.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Hi      <= '0;
      Lo      <= '0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      Done <= (state == S_FIX);
      if (state == S_FIX) begin
        Hi      <= hiRes;
        Lo      <= loRes;
        DivZero <= isDiv & bZero;
      end else if (moveOk) begin
        if (HiWrite) Hi <= MoveData;
        if (LoWrite) Lo <= MoveData;
      end
    end
  end

endmodule
